// File: rtl/bus_pkg.sv
// Shared definitions for the bus master port: FSM encoding, mode and slave-id
// constants, default widths and the bit-counter width helper.
package bus_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam logic [1:0] SLAVE_0 = 2'd0;
    localparam logic [1:0] SLAVE_1 = 2'd1;
    localparam logic [1:0] SLAVE_2 = 2'd2;
    localparam logic [1:0] SLAVE_3 = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEL1,
        ST_WAIT_GRANT,
        ST_MODE,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_DONE,
        ST_DONE
    } state_t;

    // Counter must index the longer of the address and data phases.
    function automatic int cnt_width(input int aw, input int dw);
        return (aw > dw) ? $clog2(aw) : $clog2(dw);
    endfunction

endpackage

// File: rtl/master_shift_reg.sv
// Combined PISO (address / write data out, LSB first) and SIPO (read data in,
// indexed by the bit count) with a shared phase bit counter.
module master_shift_reg
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = cnt_width(ADDR_WIDTH, DATA_WIDTH)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  cnt_clr,
    input  logic                  shift_en,
    input  logic                  sel_data,
    input  logic                  capture_en,
    input  logic                  sin,
    output logic                  sout,
    output logic [CNT_WIDTH-1:0]  cnt,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [ADDR_WIDTH-1:0] addr_sh_reg;
    logic [DATA_WIDTH-1:0] data_sh_reg;
    logic [CNT_WIDTH-1:0]  cnt_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [DATA_WIDTH-1:0] capture_mask;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_capture
            assign capture_mask[gi] = capture_en && (cnt_reg == CNT_WIDTH'(gi));
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            addr_sh_reg <= '0;
            data_sh_reg <= '0;
            cnt_reg     <= '0;
            rdata_reg   <= '0;
        end else begin
            if (load) begin
                addr_sh_reg <= load_addr;
                data_sh_reg <= load_data;
                rdata_reg   <= '0;
            end else begin
                if (shift_en) begin
                    if (sel_data) begin
                        data_sh_reg <= data_sh_reg >> 1;
                    end else begin
                        addr_sh_reg <= addr_sh_reg >> 1;
                    end
                end
                rdata_reg <= (rdata_reg & ~capture_mask) | ({DATA_WIDTH{sin}} & capture_mask);
            end
            // A phase change clears the count even on the beat that ends the phase.
            if (cnt_clr) begin
                cnt_reg <= '0;
            end else if (shift_en || capture_en) begin
                cnt_reg <= cnt_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign sout  = sel_data ? data_sh_reg[0] : addr_sh_reg[0];
    assign cnt   = cnt_reg;
    assign rdata = rdata_reg;

endmodule

// File: rtl/bus_master_port.sv
// Local-request to arbiter handshake and serial bus transfer engine; the
// grant gates every serial beat so a split simply pauses the transfer.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [1:0]            slave_id,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  m_request,
    output logic                  m_slave_sel,
    input  logic                  m_grant,
    input  logic                  arbiter_busy,
    input  logic                  bus_busy,
    output logic                  m_dout,
    output logic                  m_dout_valid,
    input  logic                  m_din,
    input  logic                  m_din_valid,
    input  logic                  trans_done
);

    localparam int CNT_WIDTH = cnt_width(ADDR_WIDTH, DATA_WIDTH);
    localparam logic [CNT_WIDTH-1:0] ADDR_LAST = CNT_WIDTH'(ADDR_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t               state_reg, state_next;
    logic                 mode_reg;
    logic [1:0]           slave_id_reg;
    logic                 err_reg, err_next;
    logic                 load, shift_en, capture_en, cnt_clr, sel_data, sout;
    logic                 on_bus;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg    <= ST_IDLE;
            mode_reg     <= MODE_READ;
            slave_id_reg <= SLAVE_0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            err_reg   <= err_next;
            if (load) begin
                mode_reg     <= mode;
                slave_id_reg <= slave_id;
            end
        end
    end

    assign on_bus = (state_reg inside {ST_MODE, ST_ADDR, ST_WDATA, ST_RDATA});

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        capture_en = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    err_next   = 1'b0;
                    state_next = ST_REQ;
                end
            end
            ST_REQ:        if (!arbiter_busy && !bus_busy) state_next = ST_SEL1;
            ST_SEL1:       state_next = ST_WAIT_GRANT;
            ST_WAIT_GRANT: if (m_grant) state_next = ST_MODE;
            ST_MODE:       if (m_grant) state_next = ST_ADDR;
            ST_ADDR: begin
                if (m_grant) begin
                    shift_en = 1'b1;
                    if (cnt == ADDR_LAST) begin
                        state_next = (mode_reg == MODE_WRITE) ? ST_WDATA : ST_RDATA;
                    end
                end
            end
            ST_WDATA: begin
                if (m_grant) begin
                    shift_en = 1'b1;
                    if (cnt == DATA_LAST) state_next = ST_WAIT_DONE;
                end
            end
            ST_RDATA: begin
                if (m_grant && m_din_valid) begin
                    capture_en = 1'b1;
                    if (cnt == DATA_LAST) state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE:  if (trans_done) state_next = ST_DONE;
            ST_DONE:       state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
        // Early end-of-transfer from the slave wins over any beat in flight.
        if (on_bus && m_grant && trans_done) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
            capture_en = 1'b0;
        end
    end

    assign cnt_clr  = (state_next != state_reg);
    assign sel_data = (state_reg == ST_WDATA);

    master_shift_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_shift (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .load       (load),
        .load_addr  (addr),
        .load_data  (wdata),
        .cnt_clr    (cnt_clr),
        .shift_en   (shift_en),
        .sel_data   (sel_data),
        .capture_en (capture_en),
        .sin        (m_din),
        .sout       (sout),
        .cnt        (cnt),
        .rdata      (rdata)
    );

    assign done         = (state_reg == ST_DONE);
    assign err          = done && err_reg;
    assign busy         = (state_reg != ST_IDLE);
    assign m_request    = (state_reg inside {ST_REQ, ST_SEL1, ST_WAIT_GRANT});
    assign m_slave_sel  = (state_reg == ST_REQ)  ? slave_id_reg[0] :
                          (state_reg == ST_SEL1) ? slave_id_reg[1] : 1'b0;
    assign m_dout_valid = m_grant && (state_reg inside {ST_MODE, ST_ADDR, ST_WDATA});
    assign m_dout       = m_dout_valid && ((state_reg == ST_MODE) ? mode_reg : sout);

endmodule

// File: tb/tb_bus_master_port.sv
// Randomized bench: plays arbiter and slave, derives the expected serial stream,
// select bits and completion from a transaction-level view of each request.
module tb_bus_master_port;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0;
    logic [1:0]  slave_id = 2'd0;
    logic [11:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  rdata;
    logic        done, err, busy, m_request, m_slave_sel, m_dout, m_dout_valid;
    logic        m_grant = 1'b0, arbiter_busy = 1'b0, bus_busy = 1'b0;
    logic        m_din = 1'b0, m_din_valid = 1'b0, trans_done = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;
    int txn_id = 0;

    always #5 sys_clk = ~sys_clk;

    bus_master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .mode         (mode),
        .slave_id     (slave_id),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .done         (done),
        .err          (err),
        .busy         (busy),
        .m_request    (m_request),
        .m_slave_sel  (m_slave_sel),
        .m_grant      (m_grant),
        .arbiter_busy (arbiter_busy),
        .bus_busy     (bus_busy),
        .m_dout       (m_dout),
        .m_dout_valid (m_dout_valid),
        .m_din        (m_din),
        .m_din_valid  (m_din_valid),
        .trans_done   (trans_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s (txn %0d): got 0x%0h expected 0x%0h", tag, txn_id, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {17'd0, rdata, done, err, busy, m_request, m_slave_sel, m_dout, m_dout_valid};
    endfunction

    // One local request end to end. split_at/abort_at are beat indices (-1 = none);
    // reset_at asserts sys_rst after that many read-data beats (-1 = none).
    task automatic run_txn(input logic md, input logic [1:0] sid, input logic [11:0] a,
                           input logic [7:0] wd, input logic [7:0] rv, input int busy_n,
                           input int split_at, input int split_len, input int abort_at,
                           input int reset_at);
        int          exp_beats, beats, din_cnt, split_left, viol_req, viol_gate, cycles, g;
        bit          split_done, aborted;
        logic [31:0] exp_stream, obs_stream;

        txn_id++;
        exp_beats  = md ? 21 : 13;
        exp_stream = md ? {11'd0, wd, a, md} : {19'd0, a, md};
        if (abort_at >= 0) begin
            exp_beats  = abort_at + 1;
            exp_stream = exp_stream & ((32'd1 << exp_beats) - 32'd1);
        end
        $display("[TB] txn %0d mode=%0d sid=%0d addr=0x%03h wdata=0x%02h rval=0x%02h busy=%0d split=%0d abort=%0d reset=%0d",
                 txn_id, md, sid, a, wd, rv, busy_n, split_at, abort_at, reset_at);

        @(negedge sys_clk);
        start = 1'b1; mode = md; slave_id = sid; addr = a; wdata = wd;
        m_grant = 1'b0; {arbiter_busy, bus_busy} = 2'b00;
        #1;
        check_eq("idle_busy", busy, 1'b0);
        check_eq("idle_req", m_request, 1'b0);

        // Arbitration: request must hold while the arbiter or bus is busy.
        for (int k = 0; k <= busy_n; k++) begin
            @(negedge sys_clk);
            start = 1'b0; addr = 12'($urandom); wdata = 8'($urandom);
            mode = 1'($urandom); slave_id = 2'($urandom);
            {arbiter_busy, bus_busy} = (k < busy_n) ? 2'($urandom_range(1, 3)) : 2'b00;
            #1;
            check_eq("req", m_request, 1'b1);
            if (k == 0) check_eq("busy", busy, 1'b1);
            if (k == busy_n) check_eq("sel0", m_slave_sel, sid[0]);
        end
        @(negedge sys_clk);
        #1;
        check_eq("sel1", {m_request, m_slave_sel}, {1'b1, sid[1]});

        g = $urandom_range(0, 3);
        for (int k = 0; k <= g; k++) begin
            @(negedge sys_clk);
            m_grant = (k == g);
            #1;
            check_eq("wait_grant", {m_request, m_slave_sel, m_dout_valid}, 3'b100);
        end

        beats = 0; din_cnt = 0; split_left = 0; split_done = 0; aborted = 0;
        viol_req = 0; viol_gate = 0; obs_stream = '0; cycles = 0;
        forever begin
            @(negedge sys_clk);
            cycles++;
            if (cycles > 300) begin
                check_eq("timeout", 1, 0);
                m_grant = 1'b0; m_din_valid = 1'b0; trans_done = 1'b0; start = 1'b0;
                return;
            end
            start = 1'($urandom);
            addr  = 12'($urandom);
            if (split_left > 0) begin
                m_grant = 1'b0;
                split_left--;
            end else if (!split_done && beats == split_at) begin
                m_grant = 1'b0;
                split_done = 1;
                split_left = split_len - 1;
            end else begin
                m_grant = 1'b1;
            end
            trans_done = m_grant && (abort_at >= 0) && (beats == abort_at);
            m_din_valid = 1'b0;
            m_din = 1'($urandom);
            if (!md && beats >= 13 && din_cnt < 8 && !trans_done) begin
                m_din_valid = 1'($urandom);
                if (m_grant) m_din = rv[din_cnt];
            end
            #1;
            if (!md && reset_at >= 0 && din_cnt == reset_at) begin
                sys_rst = 1'b1;
                #1;
                check_eq("rst_async", all_outs(), 32'd0);
                @(negedge sys_clk);
                sys_rst = 1'b0; start = 1'b0; m_grant = 1'b0;
                m_din_valid = 1'b0; trans_done = 1'b0;
                #1;
                check_eq("rst_idle", all_outs(), 32'd0);
                return;
            end
            if (m_request) viol_req++;
            if (m_dout_valid && !m_grant) viol_gate++;
            if (m_dout_valid) begin
                if (beats < 32) obs_stream[beats] = m_dout;
                beats++;
            end
            if (m_grant && m_din_valid) din_cnt++;
            if (trans_done) begin
                aborted = 1;
                break;
            end
            if (md && beats >= 21) break;
            if (!md && din_cnt >= 8) break;
        end

        check_eq("req_low", viol_req, 0);
        check_eq("valid_gate", viol_gate, 0);
        check_eq("beats", beats, exp_beats);
        check_eq("stream", obs_stream, exp_stream);

        if (!aborted) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
                @(negedge sys_clk);
                start = 1'b0; m_grant = 1'b0; m_din_valid = 1'b0; trans_done = 1'b0;
                #1;
                check_eq("wait_done", {done, busy, m_dout_valid}, 3'b010);
            end
            @(negedge sys_clk);
            start = 1'b0; m_grant = 1'b0; m_din_valid = 1'b0; trans_done = 1'b1;
            #1;
            check_eq("pre_done", done, 1'b0);
        end
        @(negedge sys_clk);
        start = 1'b0; m_grant = 1'b0; m_din_valid = 1'b0; trans_done = 1'b0;
        #1;
        check_eq("done", {done, err, busy}, {1'b1, aborted, 1'b1});
        check_eq("rdata", rdata, (md || aborted) ? 8'h00 : rv);
        @(negedge sys_clk);
        #1;
        check_eq("after_done", {done, err, busy, m_request}, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge sys_clk);
        #1;
        check_eq("reset_outs", all_outs(), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        check_eq("reset_release", all_outs(), 32'd0);

        run_txn(1'b1, 2'b10, 12'hA5C, 8'h3C, 8'h00, 0, -1, 0, -1, -1);
        run_txn(1'b0, 2'b01, 12'h1F0, 8'h00, 8'hC3, 0, -1, 0, -1, -1);
        run_txn(1'b1, 2'b11, 12'h123, 8'h9A, 8'h00, 5, -1, 0, -1, -1);
        run_txn(1'b1, 2'b00, 12'hA5C, 8'h3C, 8'h00, 0, 7, 4, -1, -1);
        run_txn(1'b1, 2'b10, 12'h5A3, 8'hF0, 8'h00, 0, -1, 0, 4, -1);
        run_txn(1'b0, 2'b01, 12'h0FF, 8'h00, 8'h6D, 0, -1, 0, -1, 3);
        run_txn(1'b0, 2'b11, 12'h800, 8'h00, 8'h81, 1, 13, 3, -1, -1);

        for (int r = 0; r < 20; r++) begin
            logic md;
            int   sp, ab;
            md = 1'($urandom);
            sp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, md ? 20 : 13)) : -1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, md ? 20 : 12)) : -1;
            run_txn(md, 2'($urandom), 12'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), sp, int'($urandom_range(1, 4)), ab, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
